exec_result_queue: RTL

Consumer end of the execute→commit result bus. Each cycle it accepts the 8-slot `execute_data_t` bundle (4 ALU, 2 MEM, 1 BR, 1 MUL), compacts the valid slots into a fixed age order, and stores them in a circular buffer. It then presents up to `POP_W` oldest results per cycle to the commit stage, and backpressures execute when free space drops below one full bundle.

---
 rtl/execute_pkg.sv | 43 ++++
 rtl/exec_slot_compact.sv | 35 +++
 rtl/exec_result_queue.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/execute_pkg.sv
// Shared execute-stage package: result types, slot ordering and the helper
// that flattens the execute->commit result bundle into age order.
package execute_pkg;

    localparam int EXEC_SLOTS  = 8;
    localparam int SLOT_IDX_W  = $clog2(EXEC_SLOTS);
    localparam int SLOT_CNT_W  = $clog2(EXEC_SLOTS + 1);
    localparam int TAG_W       = 6;
    localparam int RESULT_W    = 32;

    // One completed instruction result as seen by commit
    typedef struct packed {
        logic                valid;
        logic [TAG_W-1:0]    tag;
        logic [RESULT_W-1:0] result;
    } commit_instr_t;

    // Full execute result bus: 4 ALU, 2 MEM, 1 branch, 1 multiplier
    typedef struct packed {
        commit_instr_t [3:0] alu;
        commit_instr_t [1:0] mem;
        commit_instr_t       br;
        commit_instr_t       mul;
    } execute_data_t;

    // Slot vector, index 0 is the oldest slot
    typedef commit_instr_t [EXEC_SLOTS-1:0] exec_slot_vec_t;

    // Lay the bundle out oldest first: alu[0..3], mem[0..1], br, mul
    function automatic exec_slot_vec_t flatten_execute_data(input execute_data_t d);
        exec_slot_vec_t v;
        v[0] = d.alu[0];
        v[1] = d.alu[1];
        v[2] = d.alu[2];
        v[3] = d.alu[3];
        v[4] = d.mem[0];
        v[5] = d.mem[1];
        v[6] = d.br;
        v[7] = d.mul;
        return v;
    endfunction

endpackage

// File: rtl/exec_slot_compact.sv
// Combinational compactor: packs the valid slots of an age-ordered slot
// vector into contiguous entries starting at index 0 and reports how many
// there are. Shared by the buffer write path and the optional bypass path.
module exec_slot_compact
    import execute_pkg::*;
(
    input  exec_slot_vec_t          slots,
    output exec_slot_vec_t          entries,
    output logic [SLOT_CNT_W-1:0]   n
);

    logic [SLOT_CNT_W-1:0] prefix [EXEC_SLOTS];

    // Prefix sum: each slot's destination is the number of valid older slots
    always_comb begin
        prefix[0] = '0;
        for (int j = 1; j < EXEC_SLOTS; j++) begin
            prefix[j] = prefix[j-1] + SLOT_CNT_W'(slots[j-1].valid);
        end
        n = prefix[EXEC_SLOTS-1] + SLOT_CNT_W'(slots[EXEC_SLOTS-1].valid);
    end

    // Scatter every valid slot to its prefix position; unused entries read zero
    always_comb begin
        entries = '0;
        for (int k = 0; k < EXEC_SLOTS; k++) begin
            for (int j = 0; j < EXEC_SLOTS; j++) begin
                if (slots[j].valid && (prefix[j] == SLOT_CNT_W'(k))) begin
                    entries[k] = slots[j];
                end
            end
        end
    end

endmodule

// File: rtl/exec_result_queue.sv
// Commit-side result queue. Accepts one execute result bundle per cycle,
// compacts its valid slots in age order into a circular buffer, presents up
// to POP_W oldest results to commit and stalls execute whenever less than a
// full bundle of space would remain.
//
// Optional feature macro: EXEC_RESULT_BYPASS_EN. When defined, incoming
// results extend out_data/out_valid in the same cycle while the buffer holds
// fewer than POP_W entries, and bypass entries popped immediately are never
// written to the buffer.
module exec_result_queue
    import execute_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int POP_W = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  execute_data_t                 in_data,
    output logic                          in_stall,
    output commit_instr_t [POP_W-1:0]     out_data,
    output logic [POP_W-1:0]              out_valid,
    input  logic [$clog2(POP_W+1)-1:0]    out_pop,
    output logic [$clog2(DEPTH):0]        count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(POP_W + 1);

    // Storage and architectural state
    commit_instr_t          ram_q [DEPTH];
    logic [AW-1:0]          rptr_q;
    logic [AW-1:0]          wptr_q;
    logic [CW-1:0]          count_q;
    logic                   stall_q;

    // Incoming bundle after compaction
    exec_slot_vec_t         slots;
    exec_slot_vec_t         comp;
    logic [SLOT_CNT_W-1:0]  comp_n;
    logic [SLOT_CNT_W-1:0]  push_n;

    // Pop bookkeeping
    logic [PW-1:0]          avail;
    logic [PW-1:0]          pop_eff;
    logic [PW-1:0]          pop_buf;
    logic [SLOT_CNT_W-1:0]  pop_byp;

    // Buffer write port, one lane per possible compacted entry
    logic [SLOT_CNT_W-1:0]  wr_n;
    logic                   wr_en    [EXEC_SLOTS];
    logic [AW-1:0]          wr_idx   [EXEC_SLOTS];
    exec_slot_vec_t         wr_entry;

    logic [CW-1:0]          count_next;
    logic                   stall_next;

    assign slots    = flatten_execute_data(in_data);
    assign in_stall = stall_q;
    assign count    = count_q;

    exec_slot_compact u_compact (
        .slots   (slots),
        .entries (comp),
        .n       (comp_n)
    );

    // Slots offered while stalled are dropped rather than pushed
    always_comb begin
        push_n = stall_q ? '0 : comp_n;
    end

    // Present the oldest buffered entries, optionally followed by bypass entries
    always_comb begin
        logic [CW-1:0] byp_k;
        out_data  = '0;
        out_valid = '0;
        byp_k     = '0;
        for (int i = 0; i < POP_W; i++) begin
            byp_k = CW'(i) - count_q;
            if (CW'(i) < count_q) begin
                out_data[i]  = ram_q[rptr_q + AW'(i)];
                out_valid[i] = 1'b1;
            end
`ifdef EXEC_RESULT_BYPASS_EN
            else if (byp_k < CW'(push_n)) begin
                out_data[i]  = comp[byp_k[SLOT_IDX_W-1:0]];
                out_valid[i] = 1'b1;
            end
`endif
        end
    end

    // The legal pop ceiling is the number of entries currently offered
    always_comb begin
        avail = '0;
        for (int i = 0; i < POP_W; i++) begin
            avail = avail + PW'(out_valid[i]);
        end
    end

    // Clamp over-pops and split the pop between buffer and bypass entries
    always_comb begin
        pop_eff = (out_pop > avail) ? avail : out_pop;
`ifdef EXEC_RESULT_BYPASS_EN
        if (CW'(pop_eff) > count_q) begin
            pop_buf = PW'(count_q);
        end else begin
            pop_buf = pop_eff;
        end
        pop_byp = SLOT_CNT_W'(pop_eff - pop_buf);
`else
        pop_buf = pop_eff;
        pop_byp = '0;
`endif
        wr_n = push_n - pop_byp;
    end

    // Place the surviving compacted entries contiguously from wptr, modulo DEPTH
    always_comb begin
        logic [SLOT_IDX_W-1:0] src;
        src = '0;
        for (int k = 0; k < EXEC_SLOTS; k++) begin
            src         = SLOT_IDX_W'(k) + SLOT_IDX_W'(pop_byp);
            wr_en[k]    = SLOT_CNT_W'(k) < wr_n;
            wr_idx[k]   = wptr_q + AW'(k);
            wr_entry[k] = comp[src];
        end
    end

    // Next occupancy and the stall that keeps a full bundle of space free
    always_comb begin
        count_next = count_q + CW'(push_n) - CW'(pop_eff);
        stall_next = count_next > CW'(DEPTH - EXEC_SLOTS);
    end

    // Buffer storage; contents are don't-care after reset so it has no reset term
    always_ff @(posedge clk) begin
        for (int k = 0; k < EXEC_SLOTS; k++) begin
            if (wr_en[k]) begin
                ram_q[wr_idx[k]] <= wr_entry[k];
            end
        end
    end

    // Pointers, occupancy and the registered stall; reset overrides push and pop
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            stall_q <= 1'b0;
        end else begin
            rptr_q  <= rptr_q + AW'(pop_buf);
            wptr_q  <= wptr_q + AW'(wr_n);
            count_q <= count_next;
            stall_q <= stall_next;
        end
    end

    // Flag illegal stimulus from commit or execute during simulation
    always_ff @(posedge clk) begin
        if (resetn) begin
            assert (out_pop <= avail);
            assert (!(stall_q && (comp_n != '0)));
        end
    end

endmodule
